// File: rtl/disp_tx2.sv
`timescale 1ns/1ps
// disp_tx2: two-lane serial transmitter. Each lane buffers upstream words in
// a small FIFO; a shared framing FSM (IDLE -> TRAIN -> ACTIVE) serialises
// words MSB-first, one bit per clk8f, sending IDLE_SYM for training and
// whenever a lane has nothing to send.
//
// Ports:
//   clk8f                  bit clock, rising edge
//   reset                  synchronous, active-high
//   enable                 transmit enable
//   write0/1, data_in0/1   per-lane push strobe and data
//   out0/1                 per-lane serial bit (MSB first)
//   active                 high while the FSM is in ACTIVE
//   almost_full_f0/1       count >= MAIN_SIZE-1
//   full0/1, empty0/1      count == MAIN_SIZE / count == 0
//   fifo_error0/1          sticky overflow flags (only with DISP_TX_OVF_ERR_EN)
//
// Optional feature macro: DISP_TX_OVF_ERR_EN.
module disp_tx2 #(
  parameter int unsigned          DATA_SIZE   = 8,
  parameter int unsigned          MAIN_SIZE   = 4,
  parameter logic [DATA_SIZE-1:0] IDLE_SYM    = 8'hBC,
  parameter int unsigned          TRAIN_WORDS = 4
) (
  input  logic                 clk8f,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 write0,
  input  logic                 write1,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  output logic                 out0,
  output logic                 out1,
  output logic                 active,
  output logic                 almost_full_f0,
  output logic                 almost_full_f1,
  output logic                 full0,
  output logic                 full1,
  output logic                 empty0,
`ifdef DISP_TX_OVF_ERR_EN
  output logic                 fifo_error0,
  output logic                 fifo_error1,
`endif
  output logic                 empty1
);

  localparam int unsigned LANES = 2;
  localparam int unsigned BIT_W = $clog2(DATA_SIZE);
  localparam int unsigned PTR_W = (MAIN_SIZE > 1) ? $clog2(MAIN_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(MAIN_SIZE + 1);
  localparam int unsigned TRN_W = $clog2(TRAIN_WORDS + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAIN_SIZE - 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAIN_SIZE);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(MAIN_SIZE - 1);
  localparam logic [TRN_W-1:0] TRN_LAST = TRN_W'(TRAIN_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TRN_W-1:0]     trn_cnt_q, trn_cnt_d;
  logic                 active_q, active_d;

  logic [DATA_SIZE-1:0] sreg_q   [LANES];
  logic [DATA_SIZE-1:0] sreg_d   [LANES];
  logic [DATA_SIZE-1:0] mem_q    [LANES][MAIN_SIZE];
  logic [PTR_W-1:0]     wr_ptr_q [LANES];
  logic [PTR_W-1:0]     wr_ptr_d [LANES];
  logic [PTR_W-1:0]     rd_ptr_q [LANES];
  logic [PTR_W-1:0]     rd_ptr_d [LANES];
  logic [CNT_W-1:0]     cnt_q    [LANES];
  logic [CNT_W-1:0]     cnt_d    [LANES];

  logic [DATA_SIZE-1:0] data_w   [LANES];
  logic [LANES-1:0]     write_w;
  logic [LANES-1:0]     push_w;
  logic [LANES-1:0]     pop_w;
  logic                 boundary_w;
  logic                 send_w;

  assign write_w   = {write1, write0};
  assign data_w[0] = data_in0;
  assign data_w[1] = data_in1;

  // Word boundary: last bit of the current word is on the wire.
  assign boundary_w = (bit_cnt_q == LAST_BIT);
  // Data is only sent while staying in ACTIVE; leaving ACTIVE sends IDLE_SYM.
  assign send_w     = boundary_w && (state_q == ST_ACTIVE) && enable;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Framing FSM: transitions only at word boundaries.
  always_comb begin
    state_d   = state_q;
    trn_cnt_d = trn_cnt_q;
    if (boundary_w) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d   = ST_TRAIN;
            trn_cnt_d = '0;
          end
        end
        ST_TRAIN: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (trn_cnt_q == TRN_LAST) begin
            state_d = ST_ACTIVE;
          end else begin
            trn_cnt_d = trn_cnt_q + TRN_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!enable) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    active_d  = (state_d == ST_ACTIVE);
    bit_cnt_d = boundary_w ? '0 : bit_cnt_q + BIT_W'(1);
  end

  // Per-lane FIFO bookkeeping and serializer next state.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      pop_w[l]    = send_w && (cnt_q[l] != '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_w[l]   = write_w[l] && ((cnt_q[l] != DEPTH) || pop_w[l]);
      wr_ptr_d[l] = wr_ptr_q[l];
      rd_ptr_d[l] = rd_ptr_q[l];
      cnt_d[l]    = cnt_q[l];
      sreg_d[l]   = {sreg_q[l][DATA_SIZE-2:0], 1'b0};
      if (push_w[l]) wr_ptr_d[l] = ptr_inc(wr_ptr_q[l]);
      if (pop_w[l])  rd_ptr_d[l] = ptr_inc(rd_ptr_q[l]);
      if (push_w[l] && !pop_w[l]) begin
        cnt_d[l] = cnt_q[l] + CNT_W'(1);
      end else if (!push_w[l] && pop_w[l]) begin
        cnt_d[l] = cnt_q[l] - CNT_W'(1);
      end
      if (boundary_w) begin
        sreg_d[l] = pop_w[l] ? mem_q[l][rd_ptr_q[l]] : IDLE_SYM;
      end
    end
  end

  // Control and serializer registers.
  always_ff @(posedge clk8f) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      trn_cnt_q <= '0;
      active_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        sreg_q[l]   <= IDLE_SYM;
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      trn_cnt_q <= trn_cnt_d;
      active_q  <= active_d;
      for (int l = 0; l < LANES; l++) begin
        sreg_q[l]   <= sreg_d[l];
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        cnt_q[l]    <= cnt_d[l];
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk8f) begin
    for (int l = 0; l < LANES; l++) begin
      if (push_w[l]) mem_q[l][wr_ptr_q[l]] <= data_w[l];
    end
  end

`ifdef DISP_TX_OVF_ERR_EN
  logic [LANES-1:0] err_q, err_d;

  // Sticky: a write that was not accepted means the FIFO was full.
  always_comb begin
    err_d = err_q | (write_w & ~push_w);
  end

  always_ff @(posedge clk8f) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign fifo_error0 = err_q[0];
  assign fifo_error1 = err_q[1];
`endif

  assign out0           = sreg_q[0][DATA_SIZE-1];
  assign out1           = sreg_q[1][DATA_SIZE-1];
  assign active         = active_q;
  assign empty0         = (cnt_q[0] == '0);
  assign empty1         = (cnt_q[1] == '0);
  assign full0          = (cnt_q[0] == DEPTH);
  assign full1          = (cnt_q[1] == DEPTH);
  assign almost_full_f0 = (cnt_q[0] >= AF_LVL);
  assign almost_full_f1 = (cnt_q[1] >= AF_LVL);

endmodule

// File: tb/tb_disp_tx2.sv
`timescale 1ns/1ps
// Bench for disp_tx2: word-level reference model with per-lane expected-word
// queues, a negedge monitor that checks every transmitted word and the flags,
// directed scenarios for the framing corner cases, then randomized traffic.
module tb_disp_tx2;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TRAIN = 4;
  localparam logic [7:0]  IDLE  = 8'hBC;

  logic       clk8f = 1'b0;
  logic       reset, enable, write0, write1;
  logic [7:0] data_in0, data_in1;
  logic       out0, out1, active;
  logic       almost_full_f0, almost_full_f1, full0, full1, empty0, empty1;
`ifdef DISP_TX_OVF_ERR_EN
  logic       fifo_error0, fifo_error1;
`endif

  always #5 clk8f = ~clk8f;

  disp_tx2 dut (
    .clk8f          (clk8f),
    .reset          (reset),
    .enable         (enable),
    .write0         (write0),
    .write1         (write1),
    .data_in0       (data_in0),
    .data_in1       (data_in1),
    .out0           (out0),
    .out1           (out1),
    .active         (active),
    .almost_full_f0 (almost_full_f0),
    .almost_full_f1 (almost_full_f1),
    .full0          (full0),
    .full1          (full1),
    .empty0         (empty0),
`ifdef DISP_TX_OVF_ERR_EN
    .fifo_error0    (fifo_error0),
    .fifo_error1    (fifo_error1),
`endif
    .empty1         (empty1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: index of the bit on the wire within the current word (0 = MSB).
  // m_en_run: consecutive word boundaries seen with enable high; the link is
  // active once TRAIN+1 of them have passed (one to leave idle, TRAIN words of
  // training) and data flows from the boundary after that.
  logic [7:0] m_fifo [2][$];
  logic [7:0] m_exp  [2][$];
  int         m_phase  = 0;
  int         m_en_run = 0;
  bit         m_err [2];
  bit         m_valid  = 1'b0;

  always @(posedge clk8f) begin
    bit         wr [2];
    logic [7:0] wd [2];
    bit         send;
    wr[0] = write0; wr[1] = write1;
    wd[0] = data_in0; wd[1] = data_in1;
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        m_fifo[l].delete();
        m_exp[l].delete();
        m_exp[l].push_back(IDLE);
        m_err[l] = 1'b0;
      end
      m_phase  = 0;
      m_en_run = 0;
      m_valid  = 1'b1;
    end else begin
      if (m_phase == 7) begin
        m_en_run = enable ? m_en_run + 1 : 0;
        if (m_en_run > TRAIN + 2) m_en_run = TRAIN + 2;
        send = (m_en_run >= TRAIN + 2);
        for (int l = 0; l < 2; l++) begin
          if (send && m_fifo[l].size() > 0) m_exp[l].push_back(m_fifo[l].pop_front());
          else                              m_exp[l].push_back(IDLE);
        end
        m_phase = 0;
      end else begin
        m_phase++;
      end
      for (int l = 0; l < 2; l++) begin
        if (wr[l]) begin
          if (m_fifo[l].size() < DEPTH) m_fifo[l].push_back(wd[l]);
          else                          m_err[l] = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] acc0 = '0, acc1 = '0;

  always @(negedge clk8f) begin
    logic [7:0] e;
    if (m_valid) begin
      acc0 = {acc0[6:0], out0};
      acc1 = {acc1[6:0], out1};
      if (m_phase == 7) begin
        if (m_exp[0].size() == 0) check("sb_lane0_underrun", 0, 1);
        else begin e = m_exp[0].pop_front(); check("word_lane0", acc0, e); end
        if (m_exp[1].size() == 0) check("sb_lane1_underrun", 0, 1);
        else begin e = m_exp[1].pop_front(); check("word_lane1", acc1, e); end
      end
      check("active",  active,  m_en_run >= TRAIN + 1);
      check("empty0",  empty0,  m_fifo[0].size() == 0);
      check("empty1",  empty1,  m_fifo[1].size() == 0);
      check("full0",   full0,   m_fifo[0].size() == DEPTH);
      check("full1",   full1,   m_fifo[1].size() == DEPTH);
      check("afull0",  almost_full_f0, m_fifo[0].size() >= DEPTH - 1);
      check("afull1",  almost_full_f1, m_fifo[1].size() >= DEPTH - 1);
`ifdef DISP_TX_OVF_ERR_EN
      check("ferr0",   fifo_error0, m_err[0]);
      check("ferr1",   fifo_error1, m_err[1]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk8f);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    write0 = 1'b0;
    write1 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 16 && m_phase != p; i++) tick();
    check("wait_phase", m_phase == p, 1);
  endtask

  task automatic wait_active();
    for (int i = 0; i < 64 && active !== 1'b1; i++) tick();
    check("wait_active", active, 1);
  endtask

  task automatic capture(output logic [7:0] w0, output logic [7:0] w1);
    w0 = '0;
    w1 = '0;
    for (int i = 0; i < 8; i++) begin
      w0 = {w0[6:0], out0};
      w1 = {w1[6:0], out1};
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] c0, c1;
    logic [7:0] w [6];
    reset = 1'b1; enable = 1'b0; write0 = 1'b0; write1 = 1'b0;
    data_in0 = '0; data_in1 = '0;

    // 1) Idle after reset: four IDLE_SYM words per lane, nothing active.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      capture(c0, c1);
      check("t1_idle_lane0", c0, 8'hBC);
      check("t1_idle_lane1", c1, 8'hBC);
    end
    check("t1_active", active, 0);
    check("t1_empty0", empty0, 1);
    check("t1_empty1", empty1, 1);

    // 2) Enable right after reset: 1 idle word + 4 training words, then active.
    do_reset();
    enable = 1'b1;
    repeat (39) tick();
    check("t2_active_early", active, 0);
    tick();
    check("t2_active_on", active, 1);
    capture(c0, c1);
    check("t2_idle_active0", c0, 8'hBC);

    // 3) One word per lane while active.
    wait_phase(2);
    write0 = 1'b1; data_in0 = 8'hA5;
    write1 = 1'b1; data_in1 = 8'h3C;
    tick();
    write0 = 1'b0; write1 = 1'b0;
    check("t3_empty0_after_push", empty0, 0);
    wait_phase(0);
    check("t3_empty0_after_pop", empty0, 1);
    check("t3_empty1_after_pop", empty1, 1);
    capture(c0, c1);
    check("t3_word_lane0", c0, 8'hA5);
    check("t3_word_lane1", c1, 8'h3C);
    capture(c0, c1);
    check("t3_back_idle0", c0, 8'hBC);

    // 4) Preload lane 0 in IDLE, overflow, then push into a full FIFO at a pop.
    do_reset();
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      write0 = 1'b1; data_in0 = w[k];
      tick();
      check("t4_afull", almost_full_f0, k >= 2);
      check("t4_full",  full0, k >= 3);
    end
    write0 = 1'b0;
`ifdef DISP_TX_OVF_ERR_EN
    check("t4_fifo_error0", fifo_error0, 1);
    check("t4_fifo_error1", fifo_error1, 0);
`endif
    enable = 1'b1;
    wait_active();
    wait_phase(7);
    write0 = 1'b1; data_in0 = w[5];
    tick();
    write0 = 1'b0;
    check("t4_full_kept", full0, 1);
    for (int k = 0; k < 5; k++) begin
      capture(c0, c1);
      check("t4_order", c0, (k == 4) ? w[5] : w[k]);
    end
    check("t4_drained", empty0, 1);

    // 5) Drop enable mid-word during 0xF0: word completes, entries held.
    wait_phase(0);
    write0 = 1'b1; data_in0 = 8'hF0; tick();
    data_in0 = 8'h11; tick();
    data_in0 = 8'h22; tick();
    write0 = 1'b0;
    wait_phase(7);
    tick();
    wait_phase(3);
    enable = 1'b0;
    wait_phase(7);
    tick();
    check("t5_active_off", active, 0);
    check("t5_held", empty0, 0);
    check("t5_held_afull", almost_full_f0, 0);
    capture(c0, c1);
    check("t5_next_idle", c0, 8'hBC);

    // 6) Reset at bit 3 of a data word.
    enable = 1'b1;
    wait_active();
    for (int i = 0; i < 64 && empty0 !== 1'b1; i++) tick();
    check("t6_drain", empty0, 1);
    wait_phase(2);
    write0 = 1'b1; data_in0 = 8'h5A; tick();
    write0 = 1'b0;
    wait_phase(7);
    tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t6_out0", out0, 1);
    check("t6_out1", out1, 1);
    check("t6_empty0", empty0, 1);
    check("t6_active", active, 0);
    reset = 1'b0;
    repeat (39) tick();
    check("t6_retrain_early", active, 0);
    tick();
    check("t6_retrain_on", active, 1);

    // 7) Randomized traffic with occasional enable toggles.
    for (int n = 0; n < 3000; n++) begin
      write0   = ($urandom_range(0, 3) == 0);
      write1   = ($urandom_range(0, 4) == 0);
      data_in0 = 8'($urandom);
      data_in1 = 8'($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      tick();
    end
    write0 = 1'b0; write1 = 1'b0; enable = 1'b1;
    repeat (200) tick();
    check("t7_drain0", empty0, 1);
    check("t7_drain1", empty1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
